// File: rtl/dl11_regs_if.sv
// CPU-side register bus of the DL11 console: one-cycle strobe, registered read data.
interface dl11_regs_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output sel, we, addr, wdata, input rdata);
  modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/dl11_regs.sv
// DL11 console registers (RCSR/RBUF/XCSR/XBUF) between the CPU bus and serial_rx/serial_tx.
// Define DL11_IRQ_EN to enable the RIE/TIE bits and the rx_irq/tx_irq outputs.
module dl11_regs #(
  parameter int BUSY_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  dl11_regs_if.slave  bus,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic        rx_read,
  output logic [7:0]  tx_byte,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic        rx_irq,
  output logic        tx_irq
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] WBUSY = 2'd2;
  localparam logic [1:0] WDONE = 2'd3;
  localparam int CW = $clog2(BUSY_WAIT + 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt, cnt_nxt;
  logic          ready, ready_nxt;
  logic [7:0]    byte_nxt;
  logic          send_nxt;
  logic          done, ovr;
  logic [7:0]    rbuf;
  logic          rie, tie;
  logic          rd, wr, capture, rbuf_rd;
  logic [15:0]   rd_mux;
  logic          unused_wdata;

  assign rd           = bus.sel & ~bus.we;
  assign wr           = bus.sel & bus.we;
  assign capture      = rx_ready & ~rx_read;
  assign rbuf_rd      = rd && (bus.addr == 2'd1);
  assign unused_wdata = ^bus.wdata[15:8];

  // A capture in the same cycle as an RBUF read keeps DONE but clears OVR: the old byte was consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done    <= 1'b0;
      ovr     <= 1'b0;
      rbuf    <= 8'h00;
      rx_read <= 1'b0;
    end else begin
      rx_read <= capture;
      if (capture) begin
        rbuf <= rx_byte;
        done <= 1'b1;
        ovr  <= done & ~rbuf_rd;
      end else if (rbuf_rd) begin
        done <= 1'b0;
        ovr  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready_nxt = ready;
    cnt_nxt   = wait_cnt;
    byte_nxt  = tx_byte;
    send_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (wr && bus.addr == 2'd3 && ready) begin
          byte_nxt  = bus.wdata[7:0];
          ready_nxt = 1'b0;
          send_nxt  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        cnt_nxt   = '0;
        state_nxt = WBUSY;
      end
      WBUSY: begin
        // A transmitter that never reports busy must not wedge the console.
        if (tx_busy) begin
          state_nxt = WDONE;
        end else if (wait_cnt == CW'(BUSY_WAIT - 1)) begin
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = wait_cnt + CW'(1);
        end
      end
      WDONE: begin
        if (!tx_busy) begin
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ready    <= 1'b1;
      tx_byte  <= 8'h00;
      tx_send  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      ready    <= ready_nxt;
      tx_byte  <= byte_nxt;
      tx_send  <= send_nxt;
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (bus.addr)
      2'd0:    rd_mux = {8'b0, done, rie, 6'b0};
      2'd1:    rd_mux = {ovr, ovr, 6'b0, rbuf};
      2'd2:    rd_mux = {8'b0, ready, tie, 6'b0};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata <= 16'h0000;
    end else if (rd) begin
      bus.rdata <= rd_mux;
    end
  end

`ifdef DL11_IRQ_EN
  logic rie_nxt, tie_nxt, done_nxt;

  assign rie_nxt  = (wr && bus.addr == 2'd0) ? bus.wdata[6] : rie;
  assign tie_nxt  = (wr && bus.addr == 2'd2) ? bus.wdata[6] : tie;
  assign done_nxt = capture | (done & ~rbuf_rd);

  // Requests follow the next-state causes so they appear together with the register bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rie    <= 1'b0;
      tie    <= 1'b0;
      rx_irq <= 1'b0;
      tx_irq <= 1'b0;
    end else begin
      rie    <= rie_nxt;
      tie    <= tie_nxt;
      rx_irq <= rie_nxt & done_nxt;
      tx_irq <= tie_nxt & ready_nxt;
    end
  end
`else
  assign rie    = 1'b0;
  assign tie    = 1'b0;
  assign rx_irq = 1'b0;
  assign tx_irq = 1'b0;
`endif

endmodule

// File: tb/tb_dl11_regs.sv
// Scoreboard bench for dl11_regs: read data and transmitted bytes are queued when driven, checked on output.
module tb_dl11_regs;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        rx_read;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_busy;
  logic        rx_irq;
  logic        tx_irq;

  int total = 0;
  int bad = 0;
  int send_count = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [15:0] tx_want;

`ifdef DL11_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  localparam logic [15:0] IE_BIT = IRQ_ON ? 16'h0040 : 16'h0000;

  dl11_regs_if bus ();

  dl11_regs #(.BUSY_WAIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rx_byte  (rx_byte),
    .rx_ready (rx_ready),
    .rx_read  (rx_read),
    .tx_byte  (tx_byte),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy),
    .rx_irq   (rx_irq),
    .tx_irq   (tx_irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [15:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] a, input logic [15:0] want, input string tag);
    exp_q.push_back(want);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    tick();
    bus.sel = 1'b0;
    checkOutput(tag, bus.rdata, exp_q.pop_front());
  endtask

  task automatic rxByte(input logic [7:0] b);
    rx_byte = b; rx_ready = 1'b1;
    tick();
    checkOutput("rx_read_pulse", rx_read, 1);
    rx_ready = 1'b0;
    tick();
    checkOutput("rx_read_single", rx_read, 0);
  endtask

  // Every tx_send pulse must match a queued XBUF write.
  always @(posedge clk) begin
    #1;
    if (tx_send === 1'b1) begin
      send_count++;
      tx_want = (tx_q.size() > 0) ? {8'h00, tx_q.pop_front()} : 16'hdead;
      checkOutput("tx_byte_at_send", tx_byte, tx_want);
    end
  end

  task automatic applyStimulus();
    int n;
    int sends_before;

    repeat (2) tick();
    checkOutput("rst_rdata", bus.rdata, 0);
    checkOutput("rst_rx_read", rx_read, 0);
    checkOutput("rst_tx_send", tx_send, 0);
    checkOutput("rst_tx_byte", tx_byte, 0);
    checkOutput("rst_irqs", {rx_irq, tx_irq}, 0);
    reset = 1'b1;
    busRead(2'd0, 16'h0000, "rcsr_reset");
    busRead(2'd2, 16'h0080, "xcsr_reset");
    busRead(2'd1, 16'h0000, "rbuf_reset");

    rxByte(8'h41);
    busRead(2'd0, 16'h0080, "rcsr_done");
    busRead(2'd1, 16'h0041, "rbuf_41");
    busRead(2'd0, 16'h0000, "rcsr_cleared");

    rxByte(8'h31);
    rxByte(8'h32);
    busRead(2'd0, 16'h0080, "rcsr_ovr_done");
    busRead(2'd1, 16'hC032, "rbuf_ovr");
    busRead(2'd0, 16'h0000, "rcsr_after_ovr");
    busRead(2'd1, 16'h0032, "rbuf_ovr_cleared");

    busWrite(2'd1, 16'hFFFF);
    busRead(2'd1, 16'h0032, "rbuf_write_ignored");

    // Capture and RBUF read in the same cycle: old byte returned, DONE kept, no overrun.
    rxByte(8'h11);
    rx_byte = 8'h22; rx_ready = 1'b1;
    exp_q.push_back(16'h0011);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 2'd1;
    tick();
    bus.sel = 1'b0; rx_ready = 1'b0;
    checkOutput("cap_rd_old", bus.rdata, exp_q.pop_front());
    checkOutput("cap_rd_rx_read", rx_read, 1);
    tick();
    busRead(2'd0, 16'h0080, "cap_rd_done");
    busRead(2'd1, 16'h0022, "cap_rd_no_ovr");

    tx_q.push_back(8'h55);
    busWrite(2'd3, 16'h0155);
    busRead(2'd2, 16'h0000, "xcsr_sending");
    tx_busy = 1'b1;
    repeat (20) tick();
    busRead(2'd2, 16'h0000, "xcsr_wdone");
    tx_busy = 1'b0;
    tick();
    busRead(2'd2, 16'h0080, "xcsr_ready");
    checkOutput("tx_byte_55", tx_byte, 8'h55);

    sends_before = send_count;
    tx_q.push_back(8'h61);
    busWrite(2'd3, 16'h0061);
    busWrite(2'd3, 16'h0062);
    tx_busy = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    tick();
    busRead(2'd2, 16'h0080, "xcsr_b2b");
    checkOutput("b2b_sends", send_count - sends_before, 1);
    checkOutput("b2b_byte", tx_byte, 8'h61);

    // tx_busy never rises: four WBUSY cycles, READY set, then seen on the following read.
    tx_q.push_back(8'h77);
    busWrite(2'd3, 16'h0077);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 2'd2;
    n = 1;
    while (n <= 20) begin
      tick();
      if (bus.rdata == 16'h0080) break;
      n++;
    end
    bus.sel = 1'b0;
    checkOutput("busy_wait_cycles", n, 6);

    busWrite(2'd2, 16'h0040);
    checkOutput("tx_irq_set", tx_irq, IRQ_ON);
    busRead(2'd2, 16'h0080 | IE_BIT, "xcsr_tie");
    busWrite(2'd0, 16'h00C0);
    busRead(2'd0, IE_BIT, "rcsr_rie_only");
    rxByte(8'h0D);
    checkOutput("rx_irq_set", rx_irq, IRQ_ON);
    busRead(2'd1, 16'h000D, "rbuf_0d");
    checkOutput("rx_irq_clr", rx_irq, 0);
    tx_q.push_back(8'h44);
    busWrite(2'd3, 16'h0044);
    checkOutput("tx_irq_busy", tx_irq, 0);
    repeat (6) tick();
    checkOutput("tx_irq_back", tx_irq, IRQ_ON);
    busWrite(2'd2, 16'h0000);
    busWrite(2'd0, 16'h0000);
    checkOutput("irqs_off", {rx_irq, tx_irq}, 0);

    rxByte(8'h5A);
    busRead(2'd0, 16'h0080, "rcsr_pre_reset");
    tx_q.push_back(8'h33);
    busWrite(2'd3, 16'h0033);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_rdata", bus.rdata, 0);
    checkOutput("mid_rst_tx_send", tx_send, 0);
    checkOutput("mid_rst_tx_byte", tx_byte, 0);
    tick();
    reset = 1'b1;
    busRead(2'd0, 16'h0000, "post_rst_rcsr");
    busRead(2'd2, 16'h0080, "post_rst_xcsr");
    busRead(2'd1, 16'h0000, "post_rst_rbuf");

    checkOutput("tx_q_left", tx_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 16'h0000;
    rx_byte = 8'h00; rx_ready = 1'b0; tx_busy = 1'b0;
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
